// File: rtl/lcd_nibble_driver_if.sv
// Request/completion handshake with main_controller plus the LCD pin bundle.
// The driver owns the LCD pins; the controller only sees start/busy/finish.
interface lcd_nibble_driver_if;
  logic       lcd_start;
  logic       lcd_rs_in;
  logic [7:0] lcd_byte;
  logic       lcd_busy;
  logic       lcd_finish;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_data;

  modport master (
    output lcd_start, lcd_rs_in, lcd_byte,
    input  lcd_busy, lcd_finish
  );

  modport slave (
    input  lcd_start, lcd_rs_in, lcd_byte,
    output lcd_busy, lcd_finish, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit write engine: one byte per request, split into two enable strobes,
// followed by the LCD execution wait and a one-clock finish pulse.
//
// state      | meaning
// IDLE       | waiting for lcd_start, lcd_e low
// HI_SETUP   | high nibble and RS on the bus, lcd_e low
// HI_PULSE   | lcd_e high for the high nibble
// HI_HOLD    | lcd_e low, high nibble still driven
// GAP        | idle spacing between the two nibbles
// LO_SETUP   | low nibble on the bus, lcd_e low
// LO_PULSE   | lcd_e high for the low nibble
// LO_HOLD    | lcd_e low, low nibble still driven
// EXEC       | waiting out the LCD instruction execution time
// DONE       | lcd_finish high for one clock
module lcd_nibble_driver #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int GAP_CYC       = 50,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic              clk,
  input  logic              rst,
  lcd_nibble_driver_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HI_SETUP,
    S_HI_PULSE,
    S_HI_HOLD,
    S_GAP,
    S_LO_SETUP,
    S_LO_PULSE,
    S_LO_HOLD,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EHIGH = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(LONG_EXEC_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_byte;
  logic             r_rs_lat;
  logic             r_e;
  logic             r_rs;
  logic [3:0]       r_data;
  logic             r_busy;
  logic             r_finish;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_byte_nxt;
  logic             w_rs_lat_nxt;
  logic             w_e_nxt;
  logic             w_rs_nxt;
  logic [3:0]       w_data_nxt;
  logic             w_busy_nxt;
  logic             w_finish_nxt;
  logic             w_cnt_zero;
  logic             w_long;

  assign w_cnt_zero = (r_cnt == '0);
  // Clear display and return home (0x01..0x03) need the long execution wait.
  assign w_long = !r_rs_lat && (r_byte == 8'h01 || r_byte == 8'h02 || r_byte == 8'h03);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_cnt_zero ? '0 : r_cnt - 1'b1;
    w_byte_nxt   = r_byte;
    w_rs_lat_nxt = r_rs_lat;
    w_e_nxt      = r_e;
    w_rs_nxt     = r_rs;
    w_data_nxt   = r_data;
    w_busy_nxt   = r_busy;
    w_finish_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.lcd_start) begin
          w_state_nxt  = S_HI_SETUP;
          w_cnt_nxt    = L_SETUP;
          w_byte_nxt   = bus.lcd_byte;
          w_rs_lat_nxt = bus.lcd_rs_in;
          w_rs_nxt     = bus.lcd_rs_in;
          w_data_nxt   = bus.lcd_byte[7:4];
          w_busy_nxt   = 1'b1;
        end
      end
      S_HI_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HI_PULSE;
          w_cnt_nxt   = L_EHIGH;
          w_e_nxt     = 1'b1;
        end
      end
      S_HI_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HI_HOLD;
          w_cnt_nxt   = '0;
          w_e_nxt     = 1'b0;
        end
      end
      S_HI_HOLD: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = L_GAP;
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_LO_SETUP;
          w_cnt_nxt   = L_SETUP;
          w_data_nxt  = r_byte[3:0];
        end
      end
      S_LO_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_LO_PULSE;
          w_cnt_nxt   = L_EHIGH;
          w_e_nxt     = 1'b1;
        end
      end
      S_LO_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_LO_HOLD;
          w_cnt_nxt   = '0;
          w_e_nxt     = 1'b0;
        end
      end
      S_LO_HOLD: begin
        w_state_nxt = S_EXEC;
        w_cnt_nxt   = w_long ? L_LONG : L_EXEC;
      end
      S_EXEC: begin
        if (w_cnt_zero) begin
          w_state_nxt  = S_DONE;
          w_finish_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_e_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_rs_lat <= 1'b0;
      r_e      <= 1'b0;
      r_rs     <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_byte   <= w_byte_nxt;
      r_rs_lat <= w_rs_lat_nxt;
      r_e      <= w_e_nxt;
      r_rs     <= w_rs_nxt;
      r_data   <= w_data_nxt;
      r_busy   <= w_busy_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  assign bus.lcd_e      = r_e;
  assign bus.lcd_rs     = r_rs;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_data   = r_data;
  assign bus.lcd_busy   = r_busy;
  assign bus.lcd_finish = r_finish;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed bench for lcd_nibble_driver with shortened timing parameters.
// Edges are counted from the edge that samples lcd_start, that edge being edge 1.
module tb_lcd_nibble_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_nibble_driver_if u_if ();

  lcd_nibble_driver #(
    .SETUP_CYC    (2),
    .E_HIGH_CYC   (4),
    .GAP_CYC      (5),
    .EXEC_CYC     (10),
    .LONG_EXEC_CYC(30),
    .CNT_W        (17)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int         edge_cnt, fin_n, pulse_n, setup_bad, hold_bad, rs_bad, rw_bad, cur_len, stable;
  int         fin_e [0:3];
  int         plen  [0:7];
  logic [3:0] pdata [0:7];
  logic       saw_f, exp_rs, d_chg;
  logic       prev_e = 1'b0;
  logic       prev_rs = 1'b0;
  logic [3:0] prev_d = 4'h0;

  task automatic mon_reset(input logic rs);
    edge_cnt = 0; fin_n = 0; pulse_n = 0; setup_bad = 0; hold_bad = 0;
    rs_bad = 0; rw_bad = 0; cur_len = 0; saw_f = 1'b0; exp_rs = rs;
    for (int i = 0; i < 4; i++) fin_e[i] = -1;
    for (int i = 0; i < 8; i++) begin plen[i] = 0; pdata[i] = 4'h0; end
  endtask

  // One clock: sample 1 time unit after the rising edge and update strobe bookkeeping.
  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
    d_chg = (u_if.lcd_data !== prev_d) || (u_if.lcd_rs !== prev_rs);
    stable = d_chg ? 1 : stable + 1;
    if (u_if.lcd_e && !prev_e) begin
      if (stable < 3) setup_bad++;
      if (pulse_n < 8) pdata[pulse_n] = u_if.lcd_data;
      cur_len = 1;
    end else if (u_if.lcd_e && prev_e) begin
      cur_len++;
      if (d_chg) hold_bad++;
    end else if (!u_if.lcd_e && prev_e) begin
      if (d_chg) hold_bad++;
      if (pulse_n < 8) plen[pulse_n] = cur_len;
      pulse_n++;
    end
    if (u_if.lcd_e === 1'b1 && u_if.lcd_data === 4'hF) saw_f = 1'b1;
    if (u_if.lcd_busy === 1'b1 && u_if.lcd_rs !== exp_rs) rs_bad++;
    if (u_if.lcd_rw !== 1'b0) rw_bad++;
    if (u_if.lcd_finish === 1'b1) begin
      if (fin_n < 4) fin_e[fin_n] = edge_cnt;
      fin_n++;
    end
    prev_e  = u_if.lcd_e;
    prev_d  = u_if.lcd_data;
    prev_rs = u_if.lcd_rs;
  endtask

  task automatic do_xfer(input logic rs, input logic [7:0] b, input int inj_at,
                         input logic [7:0] inj_b, input int budget);
    mon_reset(rs);
    u_if.lcd_rs_in = rs;
    u_if.lcd_byte  = b;
    u_if.lcd_start = 1'b1;
    step();
    u_if.lcd_start = 1'b0;
    while (edge_cnt < budget) begin
      if (edge_cnt == inj_at) begin
        u_if.lcd_start = 1'b1;
        u_if.lcd_byte  = inj_b;
      end else begin
        u_if.lcd_start = 1'b0;
      end
      step();
    end
    u_if.lcd_start = 1'b0;
  endtask

  initial begin
    u_if.lcd_start = 1'b0;
    u_if.lcd_rs_in = 1'b0;
    u_if.lcd_byte  = 8'h00;
    stable = 0;
    d_chg  = 1'b0;
    mon_reset(1'b0);
    rst = 1'b1;
    step();
    step();
    chk("rst_e",      32'(u_if.lcd_e),      32'h0);
    chk("rst_busy",   32'(u_if.lcd_busy),   32'h0);
    chk("rst_finish", 32'(u_if.lcd_finish), 32'h0);
    chk("rst_data",   32'(u_if.lcd_data),   32'h0);
    chk("rst_rs",     32'(u_if.lcd_rs),     32'h0);
    chk("rst_rw",     32'(u_if.lcd_rw),     32'h0);
    rst = 1'b0;
    step();

    // data write 'A'
    do_xfer(1'b1, 8'h41, -1, 8'h00, 45);
    chk("wr_fin_n",   32'(fin_n),     32'd1);
    chk("wr_fin_e",   32'(fin_e[0]),  32'd30);
    chk("wr_pulses",  32'(pulse_n),   32'd2);
    chk("wr_len0",    32'(plen[0]),   32'd4);
    chk("wr_len1",    32'(plen[1]),   32'd4);
    chk("wr_nib0",    32'(pdata[0]),  32'h4);
    chk("wr_nib1",    32'(pdata[1]),  32'h1);
    chk("wr_setup",   32'(setup_bad), 32'd0);
    chk("wr_hold",    32'(hold_bad),  32'd0);
    chk("wr_rs",      32'(rs_bad),    32'd0);
    chk("wr_rw",      32'(rw_bad),    32'd0);
    chk("wr_idle_e",  32'(u_if.lcd_e),    32'h0);
    chk("wr_idle_bsy",32'(u_if.lcd_busy), 32'h0);
    chk("wr_idle_dat",32'(u_if.lcd_data), 32'h1);

    // clear display takes the long execution path
    do_xfer(1'b0, 8'h01, -1, 8'h00, 65);
    chk("clr_fin_n",  32'(fin_n),     32'd1);
    chk("clr_fin_e",  32'(fin_e[0]),  32'd50);
    chk("clr_nib0",   32'(pdata[0]),  32'h0);
    chk("clr_nib1",   32'(pdata[1]),  32'h1);
    chk("clr_len0",   32'(plen[0]),   32'd4);
    chk("clr_rs",     32'(rs_bad),    32'd0);

    // byte 0x00 is not a long instruction
    do_xfer(1'b0, 8'h00, -1, 8'h00, 45);
    chk("nul_fin_e",  32'(fin_e[0]),  32'd30);

    // start while busy is ignored
    do_xfer(1'b0, 8'h28, 5, 8'hFF, 45);
    chk("bsy_pulses", 32'(pulse_n),   32'd2);
    chk("bsy_nib0",   32'(pdata[0]),  32'h2);
    chk("bsy_nib1",   32'(pdata[1]),  32'h8);
    chk("bsy_no_f",   32'(saw_f),     32'h0);
    chk("bsy_fin_n",  32'(fin_n),     32'd1);
    chk("bsy_fin_e",  32'(fin_e[0]),  32'd30);

    // back-to-back with lcd_start held high
    mon_reset(1'b0);
    u_if.lcd_rs_in = 1'b0;
    u_if.lcd_byte  = 8'h0C;
    u_if.lcd_start = 1'b1;
    while (edge_cnt < 100) step();
    u_if.lcd_start = 1'b0;
    repeat (40) step();
    chk("b2b_fin_n",  32'(fin_n),             32'd4);
    chk("b2b_fin0",   32'(fin_e[0]),          32'd30);
    chk("b2b_gap1",   32'(fin_e[1] - fin_e[0]), 32'd31);
    chk("b2b_gap2",   32'(fin_e[2] - fin_e[1]), 32'd31);
    chk("b2b_setup",  32'(setup_bad),         32'd0);
    chk("b2b_hold",   32'(hold_bad),          32'd0);

    // reset during HI_PULSE aborts without a finish
    mon_reset(1'b1);
    u_if.lcd_rs_in = 1'b1;
    u_if.lcd_byte  = 8'h41;
    u_if.lcd_start = 1'b1;
    step();
    u_if.lcd_start = 1'b0;
    repeat (3) step();
    chk("ab_e_high",  32'(u_if.lcd_e),    32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_e",       32'(u_if.lcd_e),    32'h0);
    chk("ab_busy",    32'(u_if.lcd_busy), 32'h0);
    chk("ab_data",    32'(u_if.lcd_data), 32'h0);
    repeat (40) step();
    chk("ab_no_fin",  32'(fin_n),         32'd0);
    do_xfer(1'b1, 8'h41, -1, 8'h00, 45);
    chk("ab_re_fin_n",32'(fin_n),     32'd1);
    chk("ab_re_fin_e",32'(fin_e[0]),  32'd30);
    chk("ab_re_puls", 32'(pulse_n),   32'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_nibble_driver.md
Name: lcd_nibble_driver

Overview:
- Physical-side LCD write engine (HD44780-compatible, 4-bit bus, write-only) that executes one command/data byte per request from main_controller.
- Generates the two-nibble enable-strobe sequence and waits out the LCD execution time.
- Returns completion to main_controller as the lcd_finish pulse.
- Sits between main_controller and the LCD pins; exactly one transfer is in flight at a time.

Parameters:
- SETUP_CYC, 2, clocks that RS/data are stable with lcd_e low before each strobe (≥40 ns at 50 MHz).
- E_HIGH_CYC, 12, clocks lcd_e is held high per nibble (≥230 ns).
- GAP_CYC, 50, idle clocks between the high-nibble and low-nibble transfers (≥1 µs).
- EXEC_CYC, 2000, wait after the low nibble for normal instructions and data (40 µs).
- LONG_EXEC_CYC, 82000, wait after the low nibble for clear/home instructions (1.64 ms).
- CNT_W, 17, delay counter width; must hold max(all *_CYC).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- lcd_start  in  1  request strobe; sampled only while lcd_busy=0
- lcd_rs_in  in  1  0 = instruction, 1 = data; latched with lcd_start
- lcd_byte  in  8  byte to write; latched with lcd_start
- lcd_busy  out  1  high while a transfer is in progress
- lcd_finish  out  1  one-clock completion pulse to main_controller
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write select; constant 0
- lcd_data  out  4  LCD data bus, D7..D4

Behaviour:
- Reset (synchronous): state=IDLE; lcd_e=0, lcd_rs=0, lcd_data=0, lcd_busy=0, lcd_finish=0, counter=0, latches cleared. lcd_rw=0 always.
- Reset mid-transfer: on the next edge, abort to IDLE with lcd_e=0. No lcd_finish pulse is generated for the aborted transfer.
- All outputs are registered.
- States: IDLE → HI_SETUP → HI_PULSE → HI_HOLD → GAP → LO_SETUP → LO_PULSE → LO_HOLD → EXEC → DONE → IDLE.
- IDLE: if lcd_start=1, latch lcd_rs_in and lcd_byte, set lcd_busy=1, go to HI_SETUP. lcd_start is ignored in every other state, with no queueing.
- HI_SETUP:
  - lcd_data=byte[7:4], lcd_rs=latched RS, lcd_e=0.
  - Lasts SETUP_CYC clocks.
- HI_PULSE: lcd_e=1 for E_HIGH_CYC clocks; data and RS held.
- HI_HOLD: lcd_e=0 for 1 clock; data and RS held.
- GAP: GAP_CYC clocks; lcd_e=0.
- LO_SETUP / LO_PULSE / LO_HOLD: same timing as the high nibble, with lcd_data=byte[3:0].
- EXEC:
  - Counts LONG_EXEC_CYC when RS=0 and byte ∈ {0x01, 0x02, 0x03}.
  - Counts EXEC_CYC otherwise; this includes byte 0x00 and all data writes.
- DONE: lcd_finish=1 for exactly 1 clock, lcd_busy still 1. Next state is IDLE with lcd_busy=0.
- A new lcd_start is first accepted on the clock after DONE.
- Latency, defined as the number of edges from the edge that samples lcd_start to the first edge of DONE:
  - Formula: 2·SETUP_CYC + 2·E_HIGH_CYC + 2 + GAP_CYC + exec + 1.
  - Exactly one lcd_finish per accepted start.
- Counter: loaded with N−1 on state entry, decremented to 0. Any *_CYC of 0 is illegal; a value of 1 gives a single-clock state.
- Between transfers (IDLE): lcd_e=0. lcd_data and lcd_rs hold their last driven values.

Test Plan (bench overrides SETUP_CYC=2, E_HIGH_CYC=4, GAP_CYC=5, EXEC_CYC=10, LONG_EXEC_CYC=30):
- Data write: lcd_start=1 for 1 clock with rs_in=1, byte=0x41.
  - lcd_e has exactly 2 high pulses of 4 clocks each, with lcd_data=0x4 during the first and 0x1 during the second.
  - lcd_rs=1 throughout; lcd_rw=0.
  - lcd_finish pulses once, 30 edges after the start was sampled.
- Clear display: rs_in=0, byte=0x01 → lcd_finish arrives 50 edges after start (LONG_EXEC path); nibbles are 0x0 then 0x1.
- Busy rejection: start 0x28 (rs=0), then pulse lcd_start again with byte=0xFF while lcd_busy=1.
  - Only the 0x2/0x8 nibbles appear; 0xF never appears.
  - Exactly one lcd_finish.
- Back-to-back: hold lcd_start=1 continuously with byte=0x0C, rs=0.
  - A new transfer begins on the clock after each lcd_finish.
  - Successive lcd_finish pulses are 31 clocks apart.
- Reset mid-pulse: assert rst for 1 clock during HI_PULSE.
  - Next edge: lcd_e=0, lcd_busy=0, lcd_data=0.
  - No lcd_finish follows.
  - A subsequent start completes normally in 30 edges.
- Timing check: for every strobe, lcd_data and lcd_rs are stable ≥2 clocks before lcd_e rises and ≥1 clock after it falls.
